// File: rtl/switch_pkg.sv
// switch_pkg: shared sizes and packet type for the four-port switch
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int PW = $clog2(NUM_PORTS);
  typedef struct packed {
    logic [ADDR_W-1:0] source;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] rem;
  } pkt_t;
endpackage

// File: rtl/switch_if.sv
// switch_if: one switch port, input packet side plus delivered packet side
//   master: agent driving valid/source/target/data_in, observing the outputs
//   slave:  switch receiving the inputs, driving ready/valid/source/target/data_out
interface switch_if;
  import switch_pkg::*;
  logic valid_in;
  logic [ADDR_W-1:0] source_in;
  logic [ADDR_W-1:0] target_in;
  logic [DATA_W-1:0] data_in;
  logic ready_out;
  logic valid_out;
  logic [ADDR_W-1:0] source_out;
  logic [ADDR_W-1:0] target_out;
  logic [DATA_W-1:0] data_out;
  modport master (
    output valid_in, source_in, target_in, data_in,
    input ready_out, valid_out, source_out, target_out, data_out
  );
  modport slave (
    input valid_in, source_in, target_in, data_in,
    output ready_out, valid_out, source_out, target_out, data_out
  );
endinterface

// File: rtl/switch_in_fifo.sv
// switch_in_fifo: per-input packet FIFO whose head tracks a remaining delivery mask
//   wr_en/wr_pkt: packet to store (dropped when full unless the head pops this edge)
//   clr: outputs granted this cycle; cleared from the head mask, head pops when mask empties
//   head/empty: current head packet and occupancy flag
module switch_in_fifo import switch_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  pkt_t wr_pkt,
  input  logic [NUM_PORTS-1:0] clr,
  output pkt_t head,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  pkt_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic [ADDR_W-1:0] rem_next;
  logic pop, push;
  assign empty = cnt == '0;
  assign head = mem[rd];
  assign rem_next = head.rem & ~clr;
  assign pop = !empty && rem_next == '0;
  assign push = wr_en && (cnt != (AW+1)'(DEPTH) || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wr] <= wr_pkt;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      else if (!empty) mem[rd].rem <= rem_next;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/switch_four_port.sv
// switch_four_port: four-port multicast packet switch with per-output round-robin arbitration
//   clk/rst: single clock, synchronous active-high reset
//   port0..port3: switch_if slave ports; packets in, delivered packets out (ready always 1)
module switch_four_port import switch_pkg::*; (
  input logic clk,
  input logic rst,
  switch_if.slave port0,
  switch_if.slave port1,
  switch_if.slave port2,
  switch_if.slave port3
);
  pkt_t in_pkt [NUM_PORTS];
  pkt_t head [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_v, empty, gnt, vout;
  logic [NUM_PORTS-1:0] clr [NUM_PORTS];
  logic [PW-1:0] win [NUM_PORTS];
  logic [PW-1:0] ptr [NUM_PORTS];
  logic [PW-1:0] idx;
  logic [ADDR_W-1:0] out_src [NUM_PORTS];
  logic [ADDR_W-1:0] out_tgt [NUM_PORTS];
  logic [DATA_W-1:0] out_dat [NUM_PORTS];
  assign in_v = {port3.valid_in, port2.valid_in, port1.valid_in, port0.valid_in};
  assign in_pkt[0] = '{source: port0.source_in, target: port0.target_in, data: port0.data_in, rem: port0.target_in};
  assign in_pkt[1] = '{source: port1.source_in, target: port1.target_in, data: port1.data_in, rem: port1.target_in};
  assign in_pkt[2] = '{source: port2.source_in, target: port2.target_in, data: port2.data_in, rem: port2.target_in};
  assign in_pkt[3] = '{source: port3.source_in, target: port3.target_in, data: port3.data_in, rem: port3.target_in};
  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_fifo
    switch_in_fifo u_fifo (
      .clk(clk),
      .rst(rst),
      .wr_en(in_v[j] && in_pkt[j].target != '0),
      .wr_pkt(in_pkt[j]),
      .clr(clr[j]),
      .head(head[j]),
      .empty(empty[j])
    );
  end
  // Descending scan so the candidate closest to ptr overrides farther ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i] = 1'b0;
      win[i] = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = ptr[i] + PW'(k);
        if (!empty[idx] && head[idx].rem[i]) begin
          gnt[i] = 1'b1;
          win[i] = idx;
        end
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      clr[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) clr[j][i] = gnt[i] && win[i] == PW'(j);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        vout[i] <= 1'b0;
        out_src[i] <= '0;
        out_tgt[i] <= '0;
        out_dat[i] <= '0;
        ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        vout[i] <= gnt[i];
        if (gnt[i]) begin
          out_src[i] <= head[win[i]].source;
          out_tgt[i] <= head[win[i]].target;
          out_dat[i] <= head[win[i]].data;
          ptr[i] <= win[i] + 1'b1;
        end
      end
    end
  end
  assign port0.ready_out = 1'b1;
  assign port1.ready_out = 1'b1;
  assign port2.ready_out = 1'b1;
  assign port3.ready_out = 1'b1;
  assign port0.valid_out = vout[0];
  assign port1.valid_out = vout[1];
  assign port2.valid_out = vout[2];
  assign port3.valid_out = vout[3];
  assign port0.source_out = out_src[0];
  assign port1.source_out = out_src[1];
  assign port2.source_out = out_src[2];
  assign port3.source_out = out_src[3];
  assign port0.target_out = out_tgt[0];
  assign port1.target_out = out_tgt[1];
  assign port2.target_out = out_tgt[2];
  assign port3.target_out = out_tgt[3];
  assign port0.data_out = out_dat[0];
  assign port1.data_out = out_dat[1];
  assign port2.data_out = out_dat[2];
  assign port3.data_out = out_dat[3];
endmodule

// File: tb/tb_switch_four_port.sv
// tb_switch_four_port: scoreboard bench for switch_four_port with directed traffic
module tb_switch_four_port;
  import switch_pkg::*;
  typedef logic [15:0] ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic v [4];
  logic [3:0] s [4], t [4];
  logic [7:0] d [4];
  logic vo [4], ro [4];
  logic [3:0] so [4], to_ [4];
  logic [7:0] dd [4];
  ent_t exp_q [4][$];
  int checks = 0, failures = 0, pulses = 0, p0;
  logic [7:0] ov_tbl [22] = '{8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32,
                              8'h03, 8'h13, 8'h23, 8'h33, 8'h04, 8'h14, 8'h24, 8'h34, 8'h05, 8'h15, 8'h26};
  switch_if pi [4] ();
  for (genvar g = 0; g < 4; g++) begin : g_br
    assign pi[g].valid_in = v[g];
    assign pi[g].source_in = s[g];
    assign pi[g].target_in = t[g];
    assign pi[g].data_in = d[g];
    assign vo[g] = pi[g].valid_out;
    assign ro[g] = pi[g].ready_out;
    assign so[g] = pi[g].source_out;
    assign to_[g] = pi[g].target_out;
    assign dd[g] = pi[g].data_out;
  end
  switch_four_port dut (
    .clk(clk),
    .rst(rst),
    .port0(pi[0]),
    .port1(pi[1]),
    .port2(pi[2]),
    .port3(pi[3])
  );
  task automatic chk(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction
  task automatic clr_in();
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      s[i] = '0;
      t[i] = '0;
      d[i] = '0;
    end
  endtask
  task automatic put(int p, logic [3:0] src, logic [3:0] tgt, logic [7:0] dat);
    v[p] = 1'b1;
    s[p] = src;
    t[p] = tgt;
    d[p] = dat;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (vo[i] === 1'b1) begin
          pulses++;
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out%0d actual=%h required=none", i, {so[i], to_[i], dd[i]});
          end else chk($sformatf("out%0d", i), {so[i], to_[i], dd[i]}, exp_q[i].pop_front());
        end
      end
    end
  end
  initial begin
    clr_in();
    for (int i = 0; i < 4; i++) put(i, 4'(1 << i), 4'hF, 8'hFF);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk("rst_valid", 16'(vo[i]), 16'd0);
        chk("rst_data", 16'(dd[i]), 16'd0);
        chk("rst_ready", 16'(ro[i]), 16'd1);
      end
    end
    cyc();
    rst = 1'b0;
    clr_in();
    repeat (5) cyc();
    chk("idle_after_reset", 16'(pulses), 16'd0);
    put(0, 4'b0001, 4'b0100, 8'hA5);
    exp_q[2].push_back({4'b0001, 4'b0100, 8'hA5});
    cyc();
    clr_in();
    @(posedge clk);
    @(negedge clk);
    chk("uni_latency", 16'(vo[2]), 16'd1);
    repeat (3) cyc();
    chk("uni_drain", 16'(pending()), 16'd0);
    for (int p = 0; p < 4; p++) begin
      put(p, 4'(1 << p), 4'b0010, 8'(8'h10 + p));
      exp_q[1].push_back({4'(1 << p), 4'b0010, 8'(8'h10 + p)});
    end
    cyc();
    clr_in();
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("cont_drain", 16'(pending()), 16'd0);
    cyc();
    put(3, 4'b1000, 4'b1111, 8'h3C);
    for (int o = 0; o < 4; o++) exp_q[o].push_back({4'b1000, 4'b1111, 8'h3C});
    cyc();
    clr_in();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("mc_drain", 16'(pending()), 16'd0);
    cyc();
    p0 = pulses;
    put(2, 4'b0100, 4'b0000, 8'h77);
    cyc();
    clr_in();
    repeat (6) cyc();
    chk("zero_mask", 16'(pulses - p0), 16'd0);
    for (int k = 0; k < 22; k++) begin
      logic [7:0] x;
      x = ov_tbl[k];
      exp_q[3].push_back({4'(1 << x[7:4]), 4'b1000, x});
    end
    for (int c = 0; c < 7; c++) begin
      for (int j = 1; j < 4; j++) put(j, 4'(1 << j), 4'b1000, 8'((j << 4) | c));
      if (c >= 1) put(0, 4'b0001, 4'b1000, 8'(c));
      for (int i = 0; i < 4; i++) chk("ovf_ready", 16'(ro[i]), 16'd1);
      cyc();
    end
    clr_in();
    for (int n = 0; n < 40 && pending() != 0; n++) cyc();
    chk("ovf_drain", 16'(pending()), 16'd0);
    repeat (3) cyc();
    for (int p = 0; p < 4; p++) put(p, 4'(1 << p), 4'b0001, 8'(8'h50 + p));
    exp_q[0].push_back({4'b0001, 4'b0001, 8'h50});
    cyc();
    clr_in();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_valid", 16'(vo[i]), 16'd0);
      chk("midrst_data", 16'(dd[i]), 16'd0);
    end
    cyc();
    rst = 1'b0;
    p0 = pulses;
    repeat (10) cyc();
    chk("midrst_quiet", 16'(pulses - p0), 16'd0);
    chk("final_pending", 16'(pending()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
